serial_slave_port: RTL and testbench

Responder end of the bit-serial system-bus protocol driven by `master_port` and the bus bridge master. It accepts serial address/write-data frames from the bus slave slot. It performs one access on a parallel local-memory interface per frame. For reads, it returns the read data serially to the bus. It sits between a bus slave slot (`sN_*` signals) and any parallel memory or register bank, and replaces ad-hoc serial decoding inside new slave devices.

---
 rtl/serial_slave_port_if.sv | 28 ++
 rtl/serial_slave_port.sv | 165 ++++++++++++++++
 tb/tb_serial_slave_port.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_slave_port_if.sv
// Bit-serial bus slot between the system-bus master side and a serial slave port.
// Carries one serial bit each way plus the valid/ready qualifiers.
interface serial_slave_port_if;
   logic swdata;
   logic smode;
   logic mvalid;
   logic srdata;
   logic svalid;
   logic sready;

   modport master (
      output swdata,
      output smode,
      output mvalid,
      input  srdata,
      input  svalid,
      input  sready
   );

   modport slave (
      input  swdata,
      input  smode,
      input  mvalid,
      output srdata,
      output svalid,
      output sready
   );
endinterface

// File: rtl/serial_slave_port.sv
// Serial bus responder: deserialises address/write-data frames, performs one
// parallel memory access per frame and serialises read data back to the bus.
module serial_slave_port #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 8,
   parameter int MEM_SIZE   = 4096
) (
   input  logic                  clk,
   input  logic                  rst,
   serial_slave_port_if.slave    bus,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_wen,
   output logic                  mem_ren,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_rvalid
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_ADDR   = 3'd1;
   localparam logic [2:0] ST_WDATA  = 3'd2;
   localparam logic [2:0] ST_MWRITE = 3'd3;
   localparam logic [2:0] ST_MREAD  = 3'd4;
   localparam logic [2:0] ST_RDATA  = 3'd5;

   localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam int CNT_W = $clog2(MAX_W + 1);
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
   localparam logic [CNT_W-1:0] DATA_ALL  = CNT_W'(DATA_WIDTH);
   // Wide enough that MEM_SIZE >= 2**ADDR_WIDTH never truncates the limit.
   localparam logic [32:0] MEM_LIMIT = 33'(MEM_SIZE);

   logic [2:0]            state_reg;
   logic [CNT_W-1:0]      bit_cnt_reg;
   logic                  mode_reg;
   logic                  range_ok_reg;
   logic [ADDR_WIDTH-1:0] addr_sr_reg;
   logic [DATA_WIDTH-2:0] data_sr_reg;
   logic [DATA_WIDTH-2:0] rdata_sr_reg;
   logic                  srdata_reg;
   logic                  svalid_reg;
   logic                  sready_reg;
   logic [ADDR_WIDTH-1:0] mem_addr_reg;
   logic [DATA_WIDTH-1:0] mem_wdata_reg;
   logic                  mem_wen_reg;
   logic                  mem_ren_reg;

   // Values including the bit being sampled this cycle (LSB-first shift).
   logic [ADDR_WIDTH-1:0] addr_full;
   logic [DATA_WIDTH-1:0] data_full;
   logic                  addr_in_range;

   assign addr_full     = {bus.swdata, addr_sr_reg[ADDR_WIDTH-1:1]};
   assign data_full     = {bus.swdata, data_sr_reg};
   assign addr_in_range = (33'(addr_full) < MEM_LIMIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         bit_cnt_reg   <= '0;
         mode_reg      <= 1'b0;
         range_ok_reg  <= 1'b0;
         addr_sr_reg   <= '0;
         data_sr_reg   <= '0;
         rdata_sr_reg  <= '0;
         srdata_reg    <= 1'b0;
         svalid_reg    <= 1'b0;
         sready_reg    <= 1'b1;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
         mem_wen_reg   <= 1'b0;
         mem_ren_reg   <= 1'b0;
      end else begin
         mem_wen_reg <= 1'b0;
         mem_ren_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (bus.mvalid) begin
                  addr_sr_reg <= addr_full;
                  mode_reg    <= bus.smode;
                  bit_cnt_reg <= CNT_W'(1);
                  sready_reg  <= 1'b0;
                  state_reg   <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (bus.mvalid) begin
                  addr_sr_reg <= addr_full;
                  bit_cnt_reg <= bit_cnt_reg + 1'b1;
                  if (bit_cnt_reg == ADDR_LAST) begin
                     range_ok_reg <= addr_in_range;
                     bit_cnt_reg  <= '0;
                     if (mode_reg) begin
                        state_reg <= ST_WDATA;
                     end else begin
                        state_reg <= ST_MREAD;
                        if (addr_in_range) begin
                           mem_ren_reg  <= 1'b1;
                           mem_addr_reg <= addr_full;
                        end
                     end
                  end
               end
            end
            ST_WDATA: begin
               if (bus.mvalid) begin
                  data_sr_reg <= data_full[DATA_WIDTH-1:1];
                  bit_cnt_reg <= bit_cnt_reg + 1'b1;
                  if (bit_cnt_reg == DATA_LAST) begin
                     state_reg <= ST_MWRITE;
                     if (range_ok_reg) begin
                        mem_wen_reg   <= 1'b1;
                        mem_addr_reg  <= addr_sr_reg;
                        mem_wdata_reg <= data_full;
                     end
                  end
               end
            end
            ST_MWRITE: begin
               sready_reg <= 1'b1;
               state_reg  <= ST_IDLE;
            end
            ST_MREAD: begin
               // The request cycle itself never accepts mem_rvalid.
               if (!range_ok_reg) begin
                  rdata_sr_reg <= '0;
                  srdata_reg   <= 1'b0;
                  svalid_reg   <= 1'b1;
                  bit_cnt_reg  <= CNT_W'(1);
                  state_reg    <= ST_RDATA;
               end else if (!mem_ren_reg && mem_rvalid) begin
                  rdata_sr_reg <= mem_rdata[DATA_WIDTH-1:1];
                  srdata_reg   <= mem_rdata[0];
                  svalid_reg   <= 1'b1;
                  bit_cnt_reg  <= CNT_W'(1);
                  state_reg    <= ST_RDATA;
               end
            end
            ST_RDATA: begin
               if (bit_cnt_reg == DATA_ALL) begin
                  srdata_reg <= 1'b0;
                  svalid_reg <= 1'b0;
                  sready_reg <= 1'b1;
                  state_reg  <= ST_IDLE;
               end else begin
                  srdata_reg   <= rdata_sr_reg[0];
                  rdata_sr_reg <= rdata_sr_reg >> 1;
                  bit_cnt_reg  <= bit_cnt_reg + 1'b1;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign bus.srdata = srdata_reg;
   assign bus.svalid = svalid_reg;
   assign bus.sready = sready_reg;
   assign mem_addr   = mem_addr_reg;
   assign mem_wdata  = mem_wdata_reg;
   assign mem_wen    = mem_wen_reg;
   assign mem_ren    = mem_ren_reg;

endmodule

// File: tb/tb_serial_slave_port.sv
// Directed bench for serial_slave_port (A=12, D=8, MEM_SIZE=2048) with a
// latency-programmable memory model and negedge event logging.
module tb_serial_slave_port;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata = 8'h00;
   logic        mem_wen;
   logic        mem_ren;
   logic        mem_rvalid = 1'b0;

   serial_slave_port_if bus();

   serial_slave_port #(
      .ADDR_WIDTH(12),
      .DATA_WIDTH(8),
      .MEM_SIZE  (2048)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wen   (mem_wen),
      .mem_ren   (mem_ren),
      .mem_rdata (mem_rdata),
      .mem_rvalid(mem_rvalid)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   int          wen_cyc[$];
   logic [11:0] wen_addr[$];
   logic [7:0]  wen_data[$];
   int          ren_cyc[$];
   int          sv_cyc[$];
   logic        sv_bit[$];
   int          rise_cyc[$];
   int          fall_cyc[$];
   logic [7:0]  mem [0:4095];
   logic [11:0] rd_addr = 12'h000;
   int          rv_due = -1;
   int          rd_lat = 3;
   logic        extra_rv = 1'b0;
   logic        prev_sready = 1'b1;

   // Event log and memory model state; the only writer of these variables.
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_wen) begin
            wen_cyc.push_back(cyc);
            wen_addr.push_back(mem_addr);
            wen_data.push_back(mem_wdata);
            mem[mem_addr] = mem_wdata;
         end
         if (mem_ren) begin
            ren_cyc.push_back(cyc);
            rd_addr = mem_addr;
            rv_due  = cyc + rd_lat;
         end
         if (bus.svalid) begin
            sv_cyc.push_back(cyc);
            sv_bit.push_back(bus.srdata);
         end
         if (bus.sready && !prev_sready) rise_cyc.push_back(cyc);
         if (!bus.sready && prev_sready) fall_cyc.push_back(cyc);
      end
      prev_sready = bus.sready;
   end

   always @(posedge clk) begin
      #1;
      mem_rvalid = (cyc == rv_due) || extra_rv;
      mem_rdata  = (cyc == rv_due) ? mem[rd_addr] : 8'hEE;
   end

   task automatic drive_bit(input logic b, input logic m);
      @(posedge clk);
      #1;
      bus.swdata = b;
      bus.smode  = m;
      bus.mvalid = 1'b1;
   endtask

   task automatic drive_idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         bus.mvalid = 1'b0;
         bus.swdata = 1'b0;
      end
   endtask

   task automatic frame(input logic mode, input logic [11:0] a, input logic [7:0] d,
                        input int sa_bit, input int sa_n, input int sd_bit, input int sd_n,
                        input logic tog, output int t0);
      t0 = 0;
      for (int i = 0; i < 12; i++) begin
         drive_bit(a[i], (i == 0) ? mode : (tog ? ~mode : mode));
         if (i == 0) t0 = cyc;
         if (i == sa_bit) drive_idle(sa_n);
      end
      if (mode) begin
         for (int i = 0; i < 8; i++) begin
            drive_bit(d[i], tog ? ~mode : mode);
            if (i == sd_bit) drive_idle(sd_n);
         end
      end
      drive_idle(1);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.swdata = 1'b0;
      bus.smode  = 1'b0;
      bus.mvalid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({bus.sready, bus.svalid, bus.srdata, mem_wen, mem_ren} !== 5'b10000) begin
         failures++;
         $display("FAIL reset_flags got=%b want=10000",
                  {bus.sready, bus.svalid, bus.srdata, mem_wen, mem_ren});
      end
      checks++;
      if ({mem_addr, mem_wdata} !== 20'h0) begin
         failures++;
         $display("FAIL reset_bus got=%h/%h want=000/00", mem_addr, mem_wdata);
      end
      rst = 1'b0;
      drive_idle(2);
   endtask

   task automatic test_write;
      int t0;
      int wb = wen_cyc.size();
      int rb = rise_cyc.size();
      int fb = fall_cyc.size();
      frame(1'b1, 12'h123, 8'hA5, -1, 0, -1, 0, 1'b0, t0);
      repeat (10) @(posedge clk);
      #1;
      $display("write 0x123<=0xA5 start=%0d", t0);
      checks++;
      if (wen_cyc.size() - wb != 1) begin
         failures++;
         $display("FAIL write_wen_count got=%0d want=1", wen_cyc.size() - wb);
      end else begin
         checks++;
         if (wen_cyc[wb] - t0 != 20) begin
            failures++;
            $display("FAIL write_wen_cycle got=%0d want=20", wen_cyc[wb] - t0);
         end
         checks++;
         if ({wen_addr[wb], wen_data[wb]} !== {12'h123, 8'hA5}) begin
            failures++;
            $display("FAIL write_addr_data got=%h/%h want=123/a5", wen_addr[wb], wen_data[wb]);
         end
      end
      checks++;
      if (fall_cyc.size() <= fb || fall_cyc[fb] - t0 != 1) begin
         failures++;
         $display("FAIL write_sready_fall got=%0d want=1",
                  (fall_cyc.size() > fb) ? fall_cyc[fb] - t0 : -1);
      end
      checks++;
      if (rise_cyc.size() <= rb || rise_cyc[rb] - t0 != 21) begin
         failures++;
         $display("FAIL write_sready_rise got=%0d want=21",
                  (rise_cyc.size() > rb) ? rise_cyc[rb] - t0 : -1);
      end
   endtask

   // Shared by the read scenarios: checks ren count/cycle, the serial word and its timing.
   task automatic test_read_frame(input string tag, input logic [11:0] a, input int lat,
                                  input int want_ren, input logic [7:0] want,
                                  input int sv_first, input int do_poke);
      int t0;
      int sb = sv_cyc.size();
      int rn = ren_cyc.size();
      int wb = wen_cyc.size();
      int rb = rise_cyc.size();
      logic [7:0] got;
      rd_lat = lat;
      frame(1'b0, a, 8'h00, -1, 0, -1, 0, 1'b0, t0);
      if (do_poke != 0) begin
         drive_idle(2);
         @(posedge clk);
         #1;
         bus.mvalid = 1'b1;
         bus.swdata = 1'b1;
         bus.smode  = 1'b1;
         extra_rv   = 1'b1;
         @(posedge clk);
         #1;
         @(posedge clk);
         #1;
         bus.mvalid = 1'b0;
         bus.swdata = 1'b0;
         extra_rv   = 1'b0;
      end
      repeat (20) @(posedge clk);
      #1;
      $display("%s read 0x%h start=%0d", tag, a, t0);
      checks++;
      if (ren_cyc.size() - rn != want_ren) begin
         failures++;
         $display("FAIL %s_ren_count got=%0d want=%0d", tag, ren_cyc.size() - rn, want_ren);
      end else if (want_ren == 1) begin
         checks++;
         if (ren_cyc[rn] - t0 != 12) begin
            failures++;
            $display("FAIL %s_ren_cycle got=%0d want=12", tag, ren_cyc[rn] - t0);
         end
      end
      checks++;
      if (wen_cyc.size() != wb) begin
         failures++;
         $display("FAIL %s_no_wen got=%0d want=0", tag, wen_cyc.size() - wb);
      end
      checks++;
      if (sv_cyc.size() - sb != 8) begin
         failures++;
         $display("FAIL %s_svalid_count got=%0d want=8", tag, sv_cyc.size() - sb);
      end else begin
         got = 8'h00;
         for (int i = 0; i < 8; i++) got[i] = sv_bit[sb + i];
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL %s_data got=%h want=%h", tag, got, want);
         end
         checks++;
         if (sv_cyc[sb] - t0 != sv_first || sv_cyc[sb + 7] - t0 != sv_first + 7) begin
            failures++;
            $display("FAIL %s_svalid_window got=%0d..%0d want=%0d..%0d", tag,
                     sv_cyc[sb] - t0, sv_cyc[sb + 7] - t0, sv_first, sv_first + 7);
         end
      end
      checks++;
      if (rise_cyc.size() <= rb || rise_cyc[rb] - t0 != sv_first + 8) begin
         failures++;
         $display("FAIL %s_sready_rise got=%0d want=%0d", tag,
                  (rise_cyc.size() > rb) ? rise_cyc[rb] - t0 : -1, sv_first + 8);
      end
   endtask

   task automatic test_read;
      // ren at 12, rvalid at 15, svalid 16..23.
      test_read_frame("read", 12'h123, 3, 1, 8'hA5, 16, 0);
   endtask

   task automatic test_stalls;
      int t0;
      int wb = wen_cyc.size();
      frame(1'b1, 12'h7FF, 8'h3C, 5, 2, 3, 1, 1'b1, t0);
      repeat (10) @(posedge clk);
      #1;
      $display("stall write 0x7FF<=0x3C start=%0d", t0);
      checks++;
      if (wen_cyc.size() - wb != 1) begin
         failures++;
         $display("FAIL stall_wen_count got=%0d want=1", wen_cyc.size() - wb);
      end else begin
         checks++;
         if (wen_cyc[wb] - t0 != 23) begin
            failures++;
            $display("FAIL stall_wen_cycle got=%0d want=23", wen_cyc[wb] - t0);
         end
         checks++;
         if ({wen_addr[wb], wen_data[wb]} !== {12'h7FF, 8'h3C}) begin
            failures++;
            $display("FAIL stall_addr_data got=%h/%h want=7ff/3c", wen_addr[wb], wen_data[wb]);
         end
      end
   endtask

   task automatic test_out_of_range;
      int t0;
      int wb;
      int rb;
      // No request: data loaded as 0 at cycle 12, svalid 13..20.
      test_read_frame("oor", 12'h900, 3, 0, 8'h00, 13, 0);
      wb = wen_cyc.size();
      rb = rise_cyc.size();
      frame(1'b1, 12'h900, 8'h55, -1, 0, -1, 0, 1'b0, t0);
      repeat (10) @(posedge clk);
      #1;
      $display("oor write 0x900<=0x55 start=%0d", t0);
      checks++;
      if (wen_cyc.size() != wb) begin
         failures++;
         $display("FAIL oor_write_wen got=%0d want=0", wen_cyc.size() - wb);
      end
      checks++;
      if (rise_cyc.size() <= rb || rise_cyc[rb] - t0 != 21) begin
         failures++;
         $display("FAIL oor_write_sready got=%0d want=21",
                  (rise_cyc.size() > rb) ? rise_cyc[rb] - t0 : -1);
      end
   endtask

   task automatic test_rdata_ignore;
      // ren at 12, rvalid at 13, svalid 14..21; mvalid/rvalid poked at 15..16.
      test_read_frame("ignore", 12'h7FF, 1, 1, 8'h3C, 14, 1);
   endtask

   task automatic test_reset_midframe;
      int t0 = 0;
      int wb = wen_cyc.size();
      logic [11:0] a = 12'h0AA;
      logic [7:0]  d = 8'h77;
      for (int i = 0; i < 12; i++) drive_bit(a[i], 1'b1);
      for (int i = 0; i < 6; i++) drive_bit(d[i], 1'b1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      bus.mvalid = 1'b0;
      #1;
      $display("reset mid-frame after 6 data bits");
      checks++;
      if ({bus.sready, bus.svalid, bus.srdata, mem_wen, mem_ren} !== 5'b10000
          || {mem_addr, mem_wdata} !== 20'h0) begin
         failures++;
         $display("FAIL async_reset got=%b %h/%h want=10000 000/00",
                  {bus.sready, bus.svalid, bus.srdata, mem_wen, mem_ren}, mem_addr, mem_wdata);
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      drive_idle(25);
      checks++;
      if (wen_cyc.size() != wb) begin
         failures++;
         $display("FAIL abort_no_wen got=%0d want=0", wen_cyc.size() - wb);
      end
      frame(1'b1, 12'h055, 8'h66, -1, 0, -1, 0, 1'b0, t0);
      repeat (10) @(posedge clk);
      #1;
      $display("post-reset write 0x055<=0x66 start=%0d", t0);
      checks++;
      if (wen_cyc.size() - wb != 1) begin
         failures++;
         $display("FAIL post_reset_wen_count got=%0d want=1", wen_cyc.size() - wb);
      end else begin
         checks++;
         if (wen_cyc[wb] - t0 != 20 || {wen_addr[wb], wen_data[wb]} !== {12'h055, 8'h66}) begin
            failures++;
            $display("FAIL post_reset_write got=%0d %h/%h want=20 055/66",
                     wen_cyc[wb] - t0, wen_addr[wb], wen_data[wb]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_stalls();
      test_out_of_range();
      test_rdata_ignore();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
